// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if: multiplexed seven-segment bus lines plus the reconstructed per-digit readback
interface seg7_scan_decoder_if;
    logic a, b, c, d, e, f, g, dp;
    logic [7:0] ds;
    logic [31:0] digits;
    logic [7:0] dp_out, valid, blank, err;
    logic upd;
    logic [2:0] upd_idx;
    modport master (
        output a, b, c, d, e, f, g, dp, ds,
        input digits, dp_out, valid, blank, err, upd, upd_idx
    );
    modport slave (
        input a, b, c, d, e, f, g, dp, ds,
        output digits, dp_out, valid, blank, err, upd, upd_idx
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples an 8-digit multiplexed seven-segment bus and rebuilds the hex value on each position
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES = 2,
    parameter int TIMEOUT = 4096,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input logic clk,
    input logic rst,
    seg7_scan_decoder_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;
    state_t state, state_n;
    logic [7:0] s_ds, l_ds;
    logic [6:0] s_seg, l_seg;
    logic s_dp, l_dp;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic sel_ok, same, start, grow, cap, pat_ok, zero;
    logic [2:0] idx;
    logic [3:0] val;
    logic [TW-1:0] tcnt [8];
    logic [31:0] digits;
    logic [7:0] dp_out, valid, blank, err;
    logic upd;
    logic [2:0] upd_idx;
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ds <= '1;
            s_seg <= '0;
            s_dp <= 1'b0;
        end else begin
            s_ds <= bus.ds;
            s_seg <= {bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a} ^ {7{SEG_ACTIVE_LOW}};
            s_dp <= bus.dp ^ SEG_ACTIVE_LOW;
        end
    end
    assign sel_ok = $countones(~s_ds) == 1;
    assign same = {s_ds, s_seg, s_dp} == {l_ds, l_seg, l_dp};
    assign zero = s_seg == 7'h00;
    always_comb begin
        idx = '0;
        for (int i = 0; i < 8; i++)
            if (!s_ds[i]) idx = 3'(7 - i);
    end
    always_comb begin
        val = '0;
        pat_ok = 1'b0;
        for (int i = 0; i < 16; i++)
            if (s_seg == HEX[i]) begin
                val = 4'(i);
                pat_ok = 1'b1;
            end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            l_ds <= '1;
            l_seg <= '0;
            l_dp <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            if (start) begin
                l_ds <= s_ds;
                l_seg <= s_seg;
                l_dp <= s_dp;
            end
        end
    end
    // HOLD reacting to a change behaves exactly like IDLE, so both share the start term
    always_comb begin
        cnt_inc = cnt + CW'(1);
        start = sel_ok && (state == IDLE || !same);
        grow = state == TRACK && same;
        cap = (start && STABLE_CYCLES <= 1) || (grow && cnt_inc >= CW'(STABLE_CYCLES));
        cnt_n = start ? CW'(1) : grow ? cnt_inc : cnt;
        state_n = cap ? HOLD : (start || grow) ? TRACK : (state == HOLD && same) ? HOLD : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            digits <= '0;
            dp_out <= '0;
            valid <= '0;
            blank <= '0;
            err <= '0;
            upd <= 1'b0;
            upd_idx <= '0;
            for (int i = 0; i < 8; i++) tcnt[i] <= '0;
        end else begin
            upd <= cap;
            if (cap) upd_idx <= idx;
            for (int i = 0; i < 8; i++) begin
                if (cap && idx == 3'(i)) begin
                    tcnt[i] <= '0;
                    dp_out[i] <= s_dp;
                    valid[i] <= pat_ok || zero;
                    blank[i] <= zero;
                    err[i] <= !pat_ok && !zero;
                    if (pat_ok || zero) digits[4*i +: 4] <= val;
                end else if (TIMEOUT > 0 && tcnt[i] != TW'(TIMEOUT)) begin
                    tcnt[i] <= tcnt[i] + TW'(1);
                    if (tcnt[i] + TW'(1) == TW'(TIMEOUT)) valid[i] <= 1'b0;
                end
            end
        end
    end
    assign bus.digits = digits;
    assign bus.dp_out = dp_out;
    assign bus.valid = valid;
    assign bus.blank = blank;
    assign bus.err = err;
    assign bus.upd = upd;
    assign bus.upd_idx = upd_idx;
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side monitor for an 8-digit multiplexed seven-segment bus: samples segment lines a..g, dp and the active-low one-hot digit select ds.
- Reconstructs the hex value shown on each digit position, with blank/illegal flags and a per-digit staleness timeout.
- Sits on the board-side display bus as a self-check/readback block; shares the display driver's clock domain.

Parameters:
- STABLE_CYCLES, 2, consecutive identical samples (same ds, same segments) required before a capture.
- TIMEOUT, 4096, cycles without a capture after which a digit's valid bit clears; 0 disables the timeout.
- SEG_ACTIVE_LOW, 0, 1 = segment inputs (including dp) are active-low and are inverted on sampling.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- a,b,c,d,e,f,g  input  1 each  segment lines.
- dp  input  1  decimal point line.
- ds  input  8  digit select, active-low one-hot; ds[7] = position 0 … ds[0] = position 7.
- digits  output  32  captured values; digits[4i+3:4i] = position i.
- dp_out  output  8  captured dp per position.
- valid  output  8  position holds a fresh, legal capture.
- blank  output  8  last capture for the position was all segments off.
- err  output  8  last capture for the position was an unrecognised pattern.
- upd  output  1  one-cycle pulse on every capture.
- upd_idx  output  3  position captured when upd = 1.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Input stage: all inputs registered once, with inversion if SEG_ACTIVE_LOW. Pattern P = {g,f,e,d,c,b,a}, a = bit 0.
- Reset: digits = 0, dp_out = 0, valid = 0, blank = 0, err = 0, upd = 0, upd_idx = 0. The FSM goes to IDLE, and the stability counter and all timeout counters clear.
- Reset asserted mid-operation overrides everything in that cycle.
- Position index: ds must have exactly one 0 bit; the index is 7 minus the bit number of that 0. Any other ds value (all ones, or several zeros) is "no select".
- FSM states: IDLE, TRACK, HOLD.
  - IDLE: on a legal select, latch ds and the segment sample, set cnt = 1, go to TRACK.
  - TRACK, next sample identical: cnt increments. When cnt reaches STABLE_CYCLES, capture and go to HOLD.
  - TRACK, sample differs with a legal select: relatch the new sample, cnt = 1, stay in TRACK.
  - TRACK, no select: go to IDLE.
  - HOLD: stays while the sample is identical (no repeated capture). On any change, act as IDLE does in that same cycle: legal select → TRACK, otherwise → IDLE.
  - STABLE_CYCLES = 1: capture occurs on the first sample; TRACK is passed through without waiting.
- Capture latency: upd asserts STABLE_CYCLES + 1 cycles after the inputs settle (1 input register + stability count).
- Capture of position i:
  - Decode: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F.
  - Recognised pattern: digits[i] = value, err[i] = 0, blank[i] = 0, valid[i] = 1.
  - P = 00: digits[i] = 0, blank[i] = 1, err[i] = 0, valid[i] = 1.
  - Any other pattern: digits[i] unchanged, err[i] = 1, blank[i] = 0, valid[i] = 0.
  - dp_out[i] = sampled dp in all three cases.
  - upd = 1 and upd_idx = i for exactly one cycle.
- Timeout: each position has a counter that clears on its capture. When a counter reaches TIMEOUT, valid[i] clears and the counter saturates; digits, blank and err are retained.
- Simultaneous capture and timeout on the same position in one cycle: the capture wins.

Test Plan:
- Reset, then scan positions 0..7 showing 0,1,2,3,4,5,6,7 (P = 3F,06,5B,4F,66,6D,7D,07), 10 cycles each, STABLE_CYCLES = 2 → digits = 32'h76543210, valid = FF, err = 00, eight upd pulses with upd_idx 0..7.
- ds = 8'b11111110 with P = 77, dp = 1, held for 1 cycle then ds = FF → no upd. Same stimulus held for 3 cycles → exactly one upd, upd_idx = 7, digits[31:28] = A, dp_out[7] = 1.
- Position 2 receives P = 12 after a prior capture of 5 → err[2] = 1, valid[2] = 0, digits[11:8] still 5. Position 2 then receives P = 00 → blank[2] = 1, err[2] = 0, valid[2] = 1.
- ds = 8'b10111110 (two selects) for 20 cycles → FSM stays in IDLE, no upd, all outputs unchanged.
- TIMEOUT = 16: capture 9 on position 4, then stop driving position 4 → valid[4] drops exactly 16 cycles after its upd; a recapture in the same cycle the count hits 16 keeps valid[4] = 1.
- SEG_ACTIVE_LOW = 1 with P inputs = 40 on position 0 → decodes as 3F → digits[3:0] = 0. Assert rst during TRACK → all outputs zero on the next cycle, and no upd follows.
